d_brresolve: RTL

D_BRRESOLVE -- requirements
Module: d_brresolve

---
 rtl/d_brresolve.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/d_brresolve.sv
// Branch resolution for a two-slot decode stage: holds a branch across operand hazards,
// computes the real next PC, flags mispredictions and (with BRRES_BHT_EN) trains a 2-bit BHT.
module d_brresolve #(
    parameter int PC_W      = 13,
    parameter int BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      br_sel,
    input  logic [PC_W-1:0] pc1,
    input  logic [PC_W-1:0] pc2,
    input  logic [31:0]     imm1,
    input  logic [31:0]     imm2,
    input  logic [1:0]      jump_code1,
    input  logic [1:0]      jump_code2,
    input  logic [2:0]      branch_code1,
    input  logic [2:0]      branch_code2,
    input  logic [PC_W-1:0] pc_predicted,
    input  logic [31:0]     rs1_data,
    input  logic [31:0]     rs2_data,
    input  logic            cannot_calcpc,
    input  logic            flush,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_taken,
    output logic            d_stall,
    output logic            res_valid,
    output logic [PC_W-1:0] true_pc,
    output logic            fail_predict,
    output logic [15:0]     mispred_cnt
);

    localparam logic [1:0] JC_NONE   = 2'b00;
    localparam logic [1:0] JC_BRANCH = 2'b01;
    localparam logic [1:0] JC_JALR   = 2'b11;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            w_resolve;
    logic            w_capture;

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_imm;
    logic [1:0]      r_jc;
    logic [2:0]      r_bc;
    logic [PC_W-1:0] r_pred;

    logic [PC_W-1:0] r_true_pc;
    logic            r_res_valid;
    logic            r_fail;
    logic [15:0]     r_cnt;

    // Slot select: bit 1 picks slot 2, so 11 behaves as slot 2.
    logic            w_slot2;
    logic [1:0]      w_live_jc;
    logic [PC_W-1:0] w_live_pc;
    logic [PC_W-1:0] w_live_imm;
    logic [2:0]      w_live_bc;

    assign w_slot2    = br_sel[1];
    assign w_live_jc  = (br_sel == 2'b00) ? JC_NONE : (w_slot2 ? jump_code2 : jump_code1);
    assign w_live_pc  = w_slot2 ? pc2 : pc1;
    assign w_live_imm = w_slot2 ? imm2[PC_W+1:2] : imm1[PC_W+1:2];
    assign w_live_bc  = w_slot2 ? branch_code2 : branch_code1;

    // Resolution operands come from the held copy while in HOLD, else from the live slot.
    logic            w_use_held;
    logic [PC_W-1:0] w_pc;
    logic [PC_W-1:0] w_imm;
    logic [1:0]      w_jc;
    logic [2:0]      w_bc;
    logic [PC_W-1:0] w_pred;

    assign w_use_held = (r_state == S_HOLD);
    assign w_pc       = w_use_held ? r_pc   : w_live_pc;
    assign w_imm      = w_use_held ? r_imm  : w_live_imm;
    assign w_jc       = w_use_held ? r_jc   : w_live_jc;
    assign w_bc       = w_use_held ? r_bc   : w_live_bc;
    assign w_pred     = w_use_held ? r_pred : pc_predicted;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next_state = r_state;
        w_resolve    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && (w_live_jc != JC_NONE)) begin
                    if (cannot_calcpc) begin
                        w_capture    = 1'b1;
                        w_next_state = S_HOLD;
                    end else begin
                        w_resolve = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (!cannot_calcpc) begin
                    w_resolve    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    logic w_cond;
    always_comb begin
        w_cond = 1'b0;
        case (w_bc)
            3'b000:  w_cond = (rs1_data == rs2_data);
            3'b001:  w_cond = (rs1_data != rs2_data);
            3'b100:  w_cond = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  w_cond = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  w_cond = (rs1_data <  rs2_data);
            3'b111:  w_cond = (rs1_data >= rs2_data);
            default: w_cond = 1'b0;
        endcase
    end

    logic            w_taken;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_true_pc;
    logic            w_fail;

    assign w_taken   = w_jc[1] || ((w_jc == JC_BRANCH) && w_cond);
    assign w_target  = ((w_jc == JC_JALR) ? rs1_data[PC_W+1:2] : w_pc) + w_imm;
    assign w_true_pc = w_taken ? w_target : (w_pc + PC_W'(1));
    assign w_fail    = (w_true_pc != w_pred);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_imm       <= '0;
            r_jc        <= JC_NONE;
            r_bc        <= '0;
            r_pred      <= '0;
            r_true_pc   <= '0;
            r_res_valid <= 1'b0;
            r_fail      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next_state;
            r_res_valid <= w_resolve;
            if (w_capture) begin
                r_pc   <= w_live_pc;
                r_imm  <= w_live_imm;
                r_jc   <= w_live_jc;
                r_bc   <= w_live_bc;
                r_pred <= pc_predicted;
            end
            if (w_resolve) begin
                r_true_pc <= w_true_pc;
                r_fail    <= w_fail;
                if (w_fail && (r_cnt != 16'hFFFF))
                    r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign d_stall      = (r_state == S_HOLD);
    assign res_valid    = r_res_valid;
    assign true_pc      = r_true_pc;
    assign fail_predict = r_fail;
    assign mispred_cnt  = r_cnt;

`ifdef BRRES_BHT_EN
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       r_bht [BHT_DEPTH];
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_upd;

    assign w_upd_idx = w_pc[IDX_W-1:0];
    assign w_upd     = w_resolve && (w_jc == JC_BRANCH);

    // NOTE: the table must come out of reset weakly not-taken, so it is built from resettable flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                r_bht[i] <= 2'b01;
        end else if (w_upd) begin
            if (w_cond && (r_bht[w_upd_idx] != 2'b11))
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
            else if (!w_cond && (r_bht[w_upd_idx] != 2'b00))
                r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
        end
    end

    assign pred_taken = r_bht[lookup_pc[IDX_W-1:0]][1];
`else
    assign pred_taken = 1'b0;
`endif

    // Only imm[PC_W+1:2] matters in word-PC arithmetic; lookup_pc is partly or wholly unused.
    logic w_unused;
    assign w_unused = ^{imm1, imm2, lookup_pc};

endmodule
